// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
//   Command-driven controller for the LED PWM datapath. Parses byte frames
//   delivered by the SPI slave and drives one 8-bit PWM compare value per
//   channel, either by immediate set or by a timed linear fade to a target.
//
//   Frame byte0 = {op[3:0], 2'b00, ch[1:0]}; ch=3 broadcasts to all channels.
//     op 0x1 SET      2 bytes  byte1 = value
//     op 0x2 FADE     3 bytes  byte1 = target, byte2 = rate (0 -> immediate set)
//     op 0x3 STOP     1 byte   freeze compare value, clear busy
//     op 0x4 BREATHE  2 bytes  byte1 = rate (0 -> 1); only with PWM_BREATHE_EN
//
//   Build option: define PWM_BREATHE_EN to add the BREATHE op (continuous
//   0->255->0 triangle ramp). Without it op 0x4 is rejected like any unknown op.
//
// Ports
//   sysclk          system clock
//   rst_n           synchronous reset, active low
//   spi_dout        received SPI byte, valid while spi_drdy=1
//   spi_drdy        one-cycle pulse per received byte
//   spi_cs_falling  one-cycle pulse, frame start
//   spi_cs_rising   one-cycle pulse, frame end / commit point
//   comp            compare values, channel i at [8i+7:8i]
//   busy            bit i set while channel i is fading / breathing
//   frame_err       last frame rejected; cleared by the next accepted frame

module pwm_fade_sequencer #(
    parameter int CHANNELS      = 3,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic [7:0]            spi_dout,
    input  logic                  spi_drdy,
    input  logic                  spi_cs_falling,
    input  logic                  spi_cs_rising,
    output logic [8*CHANNELS-1:0] comp,
    output logic [CHANNELS-1:0]   busy,
    output logic                  frame_err
);

    localparam logic [3:0] OP_SET     = 4'h1;
    localparam logic [3:0] OP_FADE    = 4'h2;
    localparam logic [3:0] OP_STOP    = 4'h3;
`ifdef PWM_BREATHE_EN
    localparam logic [3:0] OP_BREATHE = 4'h4;
`endif
    localparam logic [2:0] CH_LIM     = 3'(CHANNELS);

    // State name = number of bytes received so far; OVER = more than three.
    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3, S_OVER} state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] op;
        logic [7:0] val;
        logic [7:0] rate;
    } cmd_t;

    state_t state_q, state_d;
    logic [3:0] op_q;
    logic [1:0] ch_q;
    logic [7:0] b1_q, b2_q;

    logic [2:0] cnt_cur, cnt_eff, req;
    logic [3:0] e_op;
    logic [1:0] e_ch;
    logic [7:0] e_b1, e_b2;
    logic       in_frame, ch_ok, frame_ok, eval;
    logic [CHANNELS-1:0] ch_mask;
    cmd_t       cmd;

    logic [PRESCALE_BITS-1:0] presc_q;
    logic                     tick;

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        eval     = 1'b0;
        in_frame = (state_q != S_IDLE);

        case (state_q)
            S_B1:    cnt_cur = 3'd1;
            S_B2:    cnt_cur = 3'd2;
            S_B3:    cnt_cur = 3'd3;
            S_OVER:  cnt_cur = 3'd4;
            default: cnt_cur = 3'd0;
        endcase

        // A byte arriving on the commit cycle is part of the frame, so the
        // evaluation sees the byte count and fields including it.
        cnt_eff = (spi_drdy && in_frame && cnt_cur != 3'd4) ? cnt_cur + 3'd1 : cnt_cur;
        e_op    = (spi_drdy && state_q == S_B0) ? spi_dout[7:4] : op_q;
        e_ch    = (spi_drdy && state_q == S_B0) ? spi_dout[1:0] : ch_q;
        e_b1    = (spi_drdy && state_q == S_B1) ? spi_dout      : b1_q;
        e_b2    = (spi_drdy && state_q == S_B2) ? spi_dout      : b2_q;

        case (e_op)
            OP_SET:     req = 3'd2;
            OP_FADE:    req = 3'd3;
            OP_STOP:    req = 3'd1;
`ifdef PWM_BREATHE_EN
            OP_BREATHE: req = 3'd2;
`endif
            default:    req = 3'd0;
        endcase

        ch_ok    = (e_ch == 2'd3) || ({1'b0, e_ch} < CH_LIM);
        // req==0 marks an unknown op; it also stops a 0-byte frame from
        // matching a stale op left in op_q.
        frame_ok = (req != 3'd0) && (cnt_eff == req) && ch_ok;

        if (spi_cs_falling) begin
            state_d = S_B0;
        end else if (spi_cs_rising && in_frame) begin
            eval    = 1'b1;
            state_d = S_IDLE;
        end else if (spi_drdy) begin
            case (state_q)
                S_B0:    state_d = S_B1;
                S_B1:    state_d = S_B2;
                S_B2:    state_d = S_B3;
                S_B3:    state_d = S_OVER;
                default: state_d = state_q;
            endcase
        end

        for (int i = 0; i < CHANNELS; i++)
            ch_mask[i] = (e_ch == 2'd3) || (e_ch == i[1:0]);

        cmd.vld  = eval && frame_ok;
        cmd.op   = e_op;
        cmd.val  = e_b1;
        cmd.rate = (e_op == OP_FADE) ? e_b2 : e_b1;
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 4'h0;
            ch_q      <= 2'd0;
            b1_q      <= 8'h00;
            b2_q      <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (spi_drdy && state_q == S_B0) begin
                op_q <= spi_dout[7:4];
                ch_q <= spi_dout[1:0];
            end
            if (spi_drdy && state_q == S_B1) b1_q <= spi_dout;
            if (spi_drdy && state_q == S_B2) b2_q <= spi_dout;
            if (eval) frame_err <= !frame_ok;
        end
    end

    // Free-running step time base; never restarted by a commit.
    always_ff @(posedge sysclk) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_q + 1'b1;
    end
    assign tick = &presc_q;

    // ------------------------------------------------------------------
    // Per-channel fade engines
    // ------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic [7:0] comp_q, tgt_q, reload_q, rcnt_q, step_comp;
        logic       busy_q, step_busy, sel;
`ifdef PWM_BREATHE_EN
        logic       brth_q, down_q, step_down;
`endif

        assign sel = cmd.vld && ch_mask[g];

        // Next compare value when the rate counter expires. Fades move one
        // LSB toward the target and never pass it, so no wrap is possible.
        always_comb begin
            step_comp = (comp_q < tgt_q) ? comp_q + 8'd1 : comp_q - 8'd1;
            step_busy = (step_comp != tgt_q);
`ifdef PWM_BREATHE_EN
            step_down = down_q;
            if (brth_q) begin
                step_busy = 1'b1;
                if (!down_q) begin
                    if (comp_q == 8'hFF) begin
                        step_comp = 8'hFE;
                        step_down = 1'b1;
                    end else begin
                        step_comp = comp_q + 8'd1;
                    end
                end else begin
                    if (comp_q == 8'h00) begin
                        step_comp = 8'h01;
                        step_down = 1'b0;
                    end else begin
                        step_comp = comp_q - 8'd1;
                    end
                end
            end
`endif
        end

        // A commit takes priority over a step landing on the same cycle.
        always_ff @(posedge sysclk) begin
            if (!rst_n) begin
                comp_q   <= 8'h00;
                tgt_q    <= 8'h00;
                reload_q <= 8'h00;
                rcnt_q   <= 8'h00;
                busy_q   <= 1'b0;
`ifdef PWM_BREATHE_EN
                brth_q   <= 1'b0;
                down_q   <= 1'b0;
`endif
            end else if (sel) begin
                case (cmd.op)
                    OP_SET: begin
                        comp_q <= cmd.val;
                        busy_q <= 1'b0;
                    end
                    OP_FADE: begin
                        if (cmd.rate == 8'd0) begin
                            comp_q <= cmd.val;
                            busy_q <= 1'b0;
                        end else begin
                            tgt_q    <= cmd.val;
                            reload_q <= cmd.rate;
                            rcnt_q   <= cmd.rate;
                            busy_q   <= (comp_q != cmd.val);
                        end
                    end
                    OP_STOP: busy_q <= 1'b0;
`ifdef PWM_BREATHE_EN
                    OP_BREATHE: begin
                        reload_q <= (cmd.rate == 8'd0) ? 8'd1 : cmd.rate;
                        rcnt_q   <= (cmd.rate == 8'd0) ? 8'd1 : cmd.rate;
                        busy_q   <= 1'b1;
                    end
`endif
                    default: ;
                endcase
`ifdef PWM_BREATHE_EN
                brth_q <= (cmd.op == OP_BREATHE);
                down_q <= 1'b0;
`endif
            end else if (tick && busy_q) begin
                if (rcnt_q == 8'd1) begin
                    rcnt_q <= reload_q;
                    comp_q <= step_comp;
                    busy_q <= step_busy;
`ifdef PWM_BREATHE_EN
                    down_q <= step_down;
`endif
                end else begin
                    rcnt_q <= rcnt_q - 8'd1;
                end
            end
        end

        assign comp[8*g +: 8] = comp_q;
        assign busy[g]        = busy_q;
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer (3 channels, 16-cycle tick).
module tb_pwm_fade_sequencer;

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  spi_dout = 8'h00;
    logic        spi_drdy = 1'b0;
    logic        spi_cs_falling = 1'b0;
    logic        spi_cs_rising = 1'b0;
    logic [23:0] comp;
    logic [2:0]  busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] bytes;   // byte0 in [7:0]
        logic [2:0]  n;
        logic        coinc;   // last byte arrives with cs_rising
        logic [23:0] comp;
        logic [2:0]  busy;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [23:0] comp;
        logic [2:0]  busy;
        logic        err;
        logic        freeze;  // expect comp unchanged across the commit
    } exp_t;

    vec_t        vecs [14];
    exp_t        sbq [$];
    logic [23:0] last_pre;

    pwm_fade_sequencer #(.CHANNELS(3), .PRESCALE_BITS(4)) dut (
        .sysclk         (sysclk),
        .rst_n          (rst_n),
        .spi_dout       (spi_dout),
        .spi_drdy       (spi_drdy),
        .spi_cs_falling (spi_cs_falling),
        .spi_cs_rising  (spi_cs_rising),
        .comp           (comp),
        .busy           (busy),
        .frame_err      (frame_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drives one frame, pushes the expectation at the commit cycle and
    // pops/compares it once the DUT has had its commit edge.
    task automatic send_frame(input string nm, input logic [31:0] bytes, input int n,
                              input bit coinc, input exp_t e);
        exp_t got;
        spi_cs_falling = 1'b1;
        @(posedge sysclk); #1 spi_cs_falling = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_dout = bytes[8*i +: 8];
            spi_drdy = 1'b1;
            if (!(coinc && i == n - 1)) begin
                @(posedge sysclk); #1 spi_drdy = 1'b0;
                @(posedge sysclk); #1;
            end
        end
        spi_cs_rising = 1'b1;
        @(negedge sysclk);
        last_pre = comp;
        if (e.freeze) e.comp = last_pre;
        sbq.push_back(e);
        @(posedge sysclk); #1;
        spi_cs_rising = 1'b0;
        spi_drdy      = 1'b0;
        @(negedge sysclk);
        got = sbq.pop_front();
        chk({nm, "_comp"}, {8'h00, comp}, {8'h00, got.comp});
        chk({nm, "_busy"}, {29'd0, busy}, {29'd0, got.busy});
        chk({nm, "_err"},  {31'd0, frame_err}, {31'd0, got.err});
    endtask

    function automatic exp_t mk(input logic [23:0] c, input logic [2:0] b, input logic er,
                                input logic fz);
        exp_t e;
        e.comp = c; e.busy = b; e.err = er; e.freeze = fz;
        return e;
    endfunction

    initial begin
        int          cyc, steps, last;
        logic [7:0]  prev, expv;
        bit          down;

        //            bytes          n     coinc  comp        busy    err
        vecs[0]  = '{32'h0000_8010, 3'd2, 1'b0, 24'h000080, 3'b000, 1'b0}; // SET ch0
        vecs[1]  = '{32'h0000_0010, 3'd1, 1'b0, 24'h000080, 3'b000, 1'b1}; // short
        vecs[2]  = '{32'h0000_5510, 3'd2, 1'b0, 24'h000055, 3'b000, 1'b0}; // clears err
        vecs[3]  = '{32'h0002_0110, 3'd3, 1'b0, 24'h000055, 3'b000, 1'b1}; // long
        vecs[4]  = '{32'h0000_0052, 3'd2, 1'b0, 24'h000055, 3'b000, 1'b1}; // bad op
        vecs[5]  = '{32'h0000_4011, 3'd2, 1'b1, 24'h004055, 3'b000, 1'b0}; // drdy+cs_rising
        vecs[6]  = '{32'h0000_0000, 3'd0, 1'b0, 24'h004055, 3'b000, 1'b1}; // 0-byte frame
        vecs[7]  = '{32'h0000_7712, 3'd2, 1'b0, 24'h774055, 3'b000, 1'b0}; // SET ch2
        vecs[8]  = '{32'h0000_9921, 3'd3, 1'b0, 24'h779955, 3'b000, 1'b0}; // FADE rate 0
        vecs[9]  = '{32'h0000_0030, 3'd1, 1'b0, 24'h779955, 3'b000, 1'b0}; // STOP idle ch
        vecs[10] = '{32'h0000_5022, 3'd2, 1'b0, 24'h779955, 3'b000, 1'b1}; // FADE short
        vecs[11] = '{32'h0000_1013, 3'd2, 1'b1, 24'h101010, 3'b000, 1'b0}; // broadcast
        vecs[12] = '{32'h0005_1020, 3'd3, 1'b0, 24'h101010, 3'b000, 1'b0}; // fade to self
        vecs[13] = '{32'h0302_0113, 3'd4, 1'b0, 24'h101010, 3'b000, 1'b1}; // 4 bytes

        // Reset state
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_comp", {8'h00, comp}, 32'h0);
        chk("rst_busy", {29'd0, busy}, 32'h0);
        chk("rst_err",  {31'd0, frame_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge sysclk);

        // Table-driven frames
        for (int i = 0; i < 14; i++)
            send_frame($sformatf("vec%0d", i), vecs[i].bytes, int'(vecs[i].n), vecs[i].coinc,
                       mk(vecs[i].comp, vecs[i].busy, vecs[i].err, 1'b0));

        // drdy while idle is ignored; cs_falling mid-frame restarts silently
        spi_dout = 8'h33; spi_drdy = 1'b1;
        @(posedge sysclk); #1 spi_drdy = 1'b0;
        spi_cs_falling = 1'b1;
        @(posedge sysclk); #1 spi_cs_falling = 1'b0;
        spi_dout = 8'h11; spi_drdy = 1'b1;
        @(posedge sysclk); #1 spi_drdy = 1'b0;
        @(negedge sysclk);
        chk("abort_err_held", {31'd0, frame_err}, 32'h1);
        send_frame("restart", 32'h0000_4011, 2, 1'b0, mk(24'h104010, 3'b000, 1'b0, 1'b0));

        // Broadcast fade 0x80 -> 0x84, rate 2: one step per 32 cycles
        send_frame("fade_set", 32'h0000_8013, 2, 1'b0, mk(24'h808080, 3'b000, 1'b0, 1'b0));
        send_frame("fade_go",  32'h0002_8423, 3, 1'b0, mk(24'h808080, 3'b111, 1'b0, 1'b0));
        cyc = 0; steps = 0; last = 0; prev = 8'h80; expv = 8'h80;
        while (steps < 4 && cyc < 400) begin
            @(negedge sysclk); cyc++;
            if (comp[7:0] != prev) begin
                steps++;
                expv = expv + 8'd1;
                chk("fade_val", {8'h00, comp}, {8'h00, expv, expv, expv});
                if (steps == 1) chk("fade_first_gap", {31'd0, (cyc >= 17 && cyc <= 32)}, 32'h1);
                else            chk("fade_gap", cyc - last, 32);
                chk("fade_busy", {29'd0, busy}, (steps == 4) ? 32'h0 : 32'h7);
                last = cyc;
                prev = comp[7:0];
            end
        end
        chk("fade_steps", steps, 4);
        repeat (100) @(negedge sysclk);
        chk("fade_hold", {8'h00, comp}, 32'h848484);
        chk("fade_hold_busy", {29'd0, busy}, 32'h0);

        // STOP mid-ramp freezes comp
        send_frame("ramp_clr", 32'h0000_0013, 2, 1'b0, mk(24'h000000, 3'b000, 1'b0, 1'b0));
        send_frame("ramp_go",  32'h0001_FF20, 3, 1'b0, mk(24'h000000, 3'b001, 1'b0, 1'b0));
        repeat (100) @(negedge sysclk);
        chk("ramp_moved", {31'd0, (comp[7:0] >= 8'd4)}, 32'h1);
        send_frame("stop", 32'h0000_0030, 1, 1'b0, mk(24'h0, 3'b000, 1'b0, 1'b1));
        repeat (60) @(negedge sysclk);
        chk("stop_hold", {8'h00, comp}, {8'h00, last_pre});
        chk("stop_hold_busy", {29'd0, busy}, 32'h0);

        // Reset in the middle of a fade
        send_frame("refade", 32'h0001_FF20, 3, 1'b0, mk(24'h0, 3'b001, 1'b0, 1'b1));
        repeat (40) @(negedge sysclk);
        chk("refade_moving", {31'd0, (comp[7:0] != last_pre[7:0])}, 32'h1);
        rst_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        chk("midrst_comp", {8'h00, comp}, 32'h0);
        chk("midrst_busy", {29'd0, busy}, 32'h0);
        chk("midrst_err",  {31'd0, frame_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge sysclk);

        // Op 0x4
        send_frame("br_set", 32'h0000_FE10, 2, 1'b0, mk(24'h0000FE, 3'b000, 1'b0, 1'b0));
`ifdef PWM_BREATHE_EN
        send_frame("br_go", 32'h0000_0140, 2, 1'b0, mk(24'h0000FE, 3'b001, 1'b0, 1'b0));
        cyc = 0; steps = 0; last = 0; prev = 8'hFE; expv = 8'hFE; down = 1'b0;
        while (steps < 257 && cyc < 257 * 16 + 64) begin
            @(negedge sysclk); cyc++;
            if (comp[7:0] != prev) begin
                steps++;
                if (!down) begin
                    if (expv == 8'hFF) begin down = 1'b1; expv = 8'hFE; end
                    else expv = expv + 8'd1;
                end else begin
                    if (expv == 8'h00) begin down = 1'b0; expv = 8'h01; end
                    else expv = expv - 8'd1;
                end
                chk("br_val", {24'd0, comp[7:0]}, {24'd0, expv});
                if (steps == 1) chk("br_first_gap", {31'd0, (cyc >= 1 && cyc <= 16)}, 32'h1);
                else            chk("br_gap", cyc - last, 16);
                last = cyc;
                prev = comp[7:0];
            end
        end
        chk("br_steps", steps, 257);
        chk("br_end", {24'd0, comp[7:0]}, 32'h01);
        chk("br_busy", {29'd0, busy}, 32'h1);
`else
        down = 1'b0;
        send_frame("op4_err", 32'h0000_0140, 2, 1'b0, mk(24'h0000FE, 3'b000, 1'b1, 1'b0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
